sram_initiator: RTL and testbench
=================================

Name: sram_initiator

Overview:
- Requester-side master for the single-port SRAM handshake (req/gnt, rvalid/rready, complemented gnt/rvalid parity lines).
- Accepts read/write commands on a valid/ready command port and issues each as one SRAM request. Returns one response per command on a valid/ready response port.
- Checks the complement parity on gnt and rvalid every cycle. Bounds every wait with a timeout.
- Sits between the core/DMA-side memory arbiter and each SRAM macro instance.

Parameters:
- DATA_WIDTH, 32, data width in bits; multiple of 8.
- NUM_WORDS, 1024, SRAM depth; ADDR_WIDTH = $clog2(NUM_WORDS) is derived, not overridable.
- TIMEOUT_CYCLES, 16, maximum wait cycles in REQ or RSP; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  word address
- cmd_wdata_i  in  DATA_WIDTH  write data
- cmd_be_i  in  DATA_WIDTH/8  byte enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_we_o  out  1  echo of the command type
- rsp_err_o  out  1  transaction timed out
- req_o  out  1  SRAM request
- we_o  out  1  SRAM write enable
- addr_o  out  ADDR_WIDTH  SRAM address
- wdata_o  out  DATA_WIDTH  SRAM write data
- be_o  out  DATA_WIDTH/8  SRAM byte enables
- rready_o  out  1  ready to take the SRAM response
- gnt_i  in  1  SRAM grant
- gntpar_i  in  1  must equal ~gnt_i
- rvalid_i  in  1  SRAM response valid
- rvalidpar_i  in  1  must equal ~rvalid_i
- rdata_i  in  DATA_WIDTH  SRAM read data
- par_err_o  out  1  sticky parity error
- proto_err_o  out  1  sticky protocol error
- err_clr_i  in  1  clears both sticky flags

Behaviour:
- Reset values:
  - All outputs 0, including req_o, rready_o, rsp_valid_o and both error flags.
  - Command register cleared.
  - State IDLE; timeout counter 0.
- FSM states: IDLE, REQ, RSP. At most one transaction outstanding.
- cmd_ready_o = (state==IDLE) && !rsp_valid_o.
- IDLE: on cmd_valid_i&cmd_ready_o, register we/addr/wdata/be and go to REQ.
- REQ:
  - req_o=1, and we_o/addr_o/wdata_o/be_o are driven from the register, stable until the grant.
  - Grant is the cycle with req_o&gnt_i; go to RSP.
  - Outside REQ, req_o=0 and addr/wdata/be/we hold their last values.
- RSP:
  - rready_o = !rsp_valid_o || rsp_ready_i (the one-entry output buffer is free or draining).
  - On rvalid_i&rready_o, load the response buffer: rdata = we ? 0 : rdata_i, err=0. Then go to IDLE.
- Response buffer:
  - rsp_valid_o is set on load and cleared on rsp_valid_o&rsp_ready_i.
  - A load and a drain in the same cycle leave rsp_valid_o=1 with the new contents.
- Latency with zero wait states: command accepted at T, req_o at T+1 (granted at T+1), rvalid_i at T+2, rsp_valid_o at T+3.
- Timeout counter:
  - Cleared on every state entry.
  - Increments each REQ cycle without gnt_i, and each RSP cycle without rvalid_i.
  - When it reaches TIMEOUT_CYCLES and the handshake is still absent, drop req_o and rready_o, load the buffer with err=1 and rdata=0, set proto_err_o, and go to IDLE.
  - If the handshake occurs in the same cycle as expiry, the handshake wins.
- Backpressure: if rsp_valid_o is held and rsp_ready_i=0, rready_o=0 in RSP. Counting continues only on cycles with rvalid_i low.
- Protocol check: rvalid_i=1 while state is IDLE or REQ sets proto_err_o (stray or late response). The stray response is otherwise ignored.
- Parity check: every cycle after reset, (gntpar_i==gnt_i) or (rvalidpar_i==rvalid_i) sets par_err_o the next cycle. Transaction flow is unaffected.
- Sticky flags:
  - err_clr_i clears both flags next cycle.
  - A set event and a clear in the same cycle leave the flag set.
- Reset mid-transaction: immediate return to IDLE. Any pending response is discarded; rsp_valid_o=0.

Decomposition:
- Package sram_if_pkg holds:
  - state enum sram_init_state_e {IDLE, REQ, RSP};
  - struct sram_rsp_t {rdata, we, err}, parameterised through a localparam width;
  - default TIMEOUT_CYCLES constant.
- Sub-module sram_par_chk: registered complement checker for gnt/rvalid plus sticky flag with clear. It is reused later by other SRAM masters.

Test Plan:
- Write 0xDEADBEEF to addr 0x010 with be=4'hF, zero-wait responder -> req_o at T+1 only; rsp_valid_o at T+3 with rsp_we_o=1, rdata=0, err=0.
- Read addr 0x010 after the write; responder returns 0xDEADBEEF -> rsp_rdata_o=0xDEADBEEF at T+3; cmd_ready_o low from T+1 until the response is consumed.
- Responder withholds gnt_i for 3 cycles -> req_o and addr_o held stable for 4 cycles; response error-free.
- rsp_ready_i=0 for 5 cycles with rvalid_i asserted -> rready_o=0 while the buffer is full; responder holds rvalid_i; data is delivered intact once rsp_ready_i=1.
- TIMEOUT_CYCLES=4, gnt_i never asserted -> req_o drops after 4 REQ cycles; rsp_err_o=1 and proto_err_o=1; a late rvalid_i pulse keeps proto_err_o=1.
- Force gntpar_i=gnt_i for one cycle -> par_err_o=1 the next cycle and stays set; err_clr_i pulse -> 0; transactions unaffected throughout.

Source files
------------

// File: rtl/sram_if_pkg.sv
// Shared types and defaults for the SRAM requester/responder handshake.
package sram_if_pkg;

  localparam int unsigned SRAM_DATA_WIDTH     = 32;
  localparam int unsigned SRAM_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } sram_init_state_e;

  // Response buffer payload; the data field tracks the default data width.
  typedef struct packed {
    logic [SRAM_DATA_WIDTH-1:0] rdata;
    logic                       we;
    logic                       err;
  } sram_rsp_t;

endpackage

// File: rtl/sram_par_chk.sv
// Registered complement-parity checker for gnt/rvalid with a sticky, clearable flag.
module sram_par_chk (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic gnt_i,
  input  logic gntpar_i,
  input  logic rvalid_i,
  input  logic rvalidpar_i,
  input  logic clr_i,
  output logic par_err_o
);

  logic mismatch_c;
  logic err_q;

  assign mismatch_c = (gntpar_i == gnt_i) || (rvalidpar_i == rvalid_i);

  // A new mismatch beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= mismatch_c | (err_q & ~clr_i);
    end
  end

  assign par_err_o = err_q;

endmodule

// File: rtl/sram_initiator.sv
// Requester-side SRAM master: one outstanding command, bounded waits, parity and protocol checks.
module sram_initiator
  import sram_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = SRAM_DATA_WIDTH,
  parameter int unsigned NUM_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = SRAM_TIMEOUT_CYCLES,
  localparam int unsigned ADDR_WIDTH    = $clog2(NUM_WORDS),
  localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [BE_WIDTH-1:0]   cmd_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_we_o,
  output logic                  rsp_err_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [BE_WIDTH-1:0]   be_o,
  output logic                  rready_o,
  input  logic                  gnt_i,
  input  logic                  gntpar_i,
  input  logic                  rvalid_i,
  input  logic                  rvalidpar_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  par_err_o,
  output logic                  proto_err_o,
  input  logic                  err_clr_i
);

  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  sram_init_state_e      state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  cmd_we_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic [BE_WIDTH-1:0]   cmd_be_q;
  sram_rsp_t             rsp_q, rsp_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  req_q;
  logic                  cmd_ready_q;
  logic                  proto_err_q;

  logic rready_c, accept_c, drain_c, expire_c, load_c, timeout_c, proto_set_c;

  assign rready_c = (state_q == RSP) && (!rsp_valid_q || rsp_ready_i);
  assign accept_c = cmd_valid_i && cmd_ready_q;
  assign drain_c  = rsp_valid_q && rsp_ready_i;
  // Expiry is the cycle on which the wait count would reach the limit.
  assign expire_c = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);

  // Next state, wait counter and response-buffer load.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rsp_d     = rsp_q;
    load_c    = 1'b0;
    timeout_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (gnt_i) begin
          state_d = RSP;
          cnt_d   = '0;
        end else if (expire_c) begin
          timeout_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RSP: begin
        if (rvalid_i && rready_c) begin
          load_c      = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
          rsp_d.rdata = cmd_we_q ? {SRAM_DATA_WIDTH{1'b0}} : SRAM_DATA_WIDTH'(rdata_i);
          rsp_d.we    = cmd_we_q;
          rsp_d.err   = 1'b0;
        end else if (!rvalid_i) begin
          if (expire_c) begin
            timeout_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_c) begin
      load_c      = 1'b1;
      state_d     = IDLE;
      cnt_d       = '0;
      rsp_d.rdata = '0;
      rsp_d.we    = cmd_we_q;
      rsp_d.err   = 1'b1;
    end
  end

  // A load wins over a same-cycle drain so the new response stays visible.
  assign rsp_valid_d = load_c ? 1'b1 : (drain_c ? 1'b0 : rsp_valid_q);
  assign proto_set_c = timeout_c || (rvalid_i && (state_q != RSP));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      req_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      req_q       <= (state_d == REQ);
      cmd_ready_q <= (state_d == IDLE) && !rsp_valid_d;
      proto_err_q <= proto_set_c | (proto_err_q & ~err_clr_i);
      if (load_c) begin
        rsp_q <= rsp_d;
      end
      if (accept_c) begin
        cmd_we_q    <= cmd_we_i;
        cmd_addr_q  <= cmd_addr_i;
        cmd_wdata_q <= cmd_wdata_i;
        cmd_be_q    <= cmd_be_i;
      end
    end
  end

  sram_par_chk u_par_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .gnt_i       (gnt_i),
    .gntpar_i    (gntpar_i),
    .rvalid_i    (rvalid_i),
    .rvalidpar_i (rvalidpar_i),
    .clr_i       (err_clr_i),
    .par_err_o   (par_err_o)
  );

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = DATA_WIDTH'(rsp_q.rdata);
  assign rsp_we_o    = rsp_q.we;
  assign rsp_err_o   = rsp_q.err;
  assign req_o       = req_q;
  assign we_o        = cmd_we_q;
  assign addr_o      = cmd_addr_q;
  assign wdata_o     = cmd_wdata_q;
  assign be_o        = cmd_be_q;
  assign rready_o    = rready_c;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_sram_initiator.sv
// Directed bench for sram_initiator with a small SRAM responder model (timeout limit 4).
module tb_sram_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready_o, cmd_we;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid_o, rsp_ready, rsp_we_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        req_o, we_o, rready_o;
  logic [9:0]  addr_o;
  logic [31:0] wdata_o, rdata_i;
  logic [3:0]  be_o;
  logic        gnt_i, gntpar_i, rvalid_i, rvalidpar_i;
  logic        par_err_o, proto_err_o, err_clr;

  // Responder controls
  logic        gnt_never, rsp_never, flip_gpar, flip_rpar, stray, flush;
  int unsigned gnt_delay;
  int unsigned wait_cnt;
  logic        pending;
  logic [31:0] rdata_q;
  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_initiator #(.DATA_WIDTH(32), .NUM_WORDS(1024), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
    .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .rready_o(rready_o), .gnt_i(gnt_i), .gntpar_i(gntpar_i),
    .rvalid_i(rvalid_i), .rvalidpar_i(rvalidpar_i), .rdata_i(rdata_i),
    .par_err_o(par_err_o), .proto_err_o(proto_err_o), .err_clr_i(err_clr)
  );

  assign gnt_i       = req_o && !gnt_never && (wait_cnt >= gnt_delay);
  assign gntpar_i    = ~gnt_i ^ flip_gpar;
  assign rvalid_i    = (pending && !rsp_never) || stray;
  assign rvalidpar_i = ~rvalid_i ^ flip_rpar;
  assign rdata_i     = (pending && !rsp_never) ? rdata_q : 32'h0;

  // SRAM model: grant after gnt_delay wait cycles, respond the cycle after grant.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      wait_cnt <= 0;
      rdata_q  <= 32'h0;
    end else begin
      wait_cnt <= (req_o && !gnt_i) ? wait_cnt + 1 : 0;
      if (req_o && gnt_i) begin
        pending <= 1'b1;
        rdata_q <= mem[addr_o];
        if (we_o) begin
          for (int b = 0; b < 4; b++) begin
            if (be_o[b]) mem[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
          end
        end
      end else if ((rvalid_i && rready_o) || flush) begin
        pending <= 1'b0;
      end
    end
  end

  task automatic run_txn(input logic we, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic got, output logic [31:0] rd,
                         output logic rerr);
    got = 1'b0; rd = 32'h0; rerr = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_be = be;
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    for (int n = 0; n < 30 && !got; n++) begin
      if (rsp_valid_o) begin
        got = 1'b1; rd = rsp_rdata_o; rerr = rsp_err_o;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if ({req_o, rready_o, rsp_valid_o, cmd_ready_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_hs req/rready/rsp_valid/cmd_ready=%b exp=0000",
                         {req_o, rready_o, rsp_valid_o, cmd_ready_o});
    end
    checks++; if ({par_err_o, proto_err_o, addr_o} !== 12'h000) begin
      errors++; $display("FAIL reset_err par=%b proto=%b addr=%h exp 0", par_err_o, proto_err_o, addr_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready cmd_ready_o=%b exp=1", cmd_ready_o);
    end
  endtask

  // Zero-wait command with per-cycle latency checks; exp_rd is the required response data.
  task automatic txn_zero_wait(input string nm, input logic we, input logic [9:0] a,
                               input logic [31:0] d, input logic [31:0] exp_rd);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_be = 4'hF;
    checks++; if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s_t0_ready cmd_ready_o=%b exp=1", nm, cmd_ready_o);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if ({req_o, we_o, addr_o, wdata_o, be_o, cmd_ready_o} !== {1'b1, we, a, d, 4'hF, 1'b0}) begin
      errors++; $display("FAIL %s_t1_req req=%b we=%b addr=%h wdata=%h be=%h ready=%b exp req=1 we=%b addr=%h wdata=%h be=f ready=0",
                         nm, req_o, we_o, addr_o, wdata_o, be_o, cmd_ready_o, we, a, d);
    end
    @(negedge clk);
    checks++; if ({req_o, rready_o, rsp_valid_o, cmd_ready_o} !== 4'b0100) begin
      errors++; $display("FAIL %s_t2 req/rready/rsp_valid/ready=%b exp=0100", nm,
                         {req_o, rready_o, rsp_valid_o, cmd_ready_o});
    end
    @(negedge clk);
    checks++; if ({rsp_valid_o, rsp_we_o, rsp_err_o, rsp_rdata_o, cmd_ready_o} !== {1'b1, we, 1'b0, exp_rd, 1'b0}) begin
      errors++; $display("FAIL %s_t3_rsp valid=%b we=%b err=%b rdata=%h ready=%b exp valid=1 we=%b err=0 rdata=%h ready=0",
                         nm, rsp_valid_o, rsp_we_o, rsp_err_o, rsp_rdata_o, cmd_ready_o, we, exp_rd);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
      errors++; $display("FAIL %s_t4_drain rsp_valid=%b cmd_ready=%b exp 0 1", nm, rsp_valid_o, cmd_ready_o);
    end
  endtask

  task automatic test_write();
    txn_zero_wait("wr", 1'b1, 10'h010, 32'hDEADBEEF, 32'h0);
  endtask

  task automatic test_read();
    txn_zero_wait("rd", 1'b0, 10'h010, 32'h0, 32'hDEADBEEF);
  endtask

  task automatic test_gnt_wait();
    gnt_delay = 3;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h010; cmd_be = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if ({req_o, addr_o} !== {1'b1, 10'h010}) begin
        errors++; $display("FAIL gw_hold_c%0d req=%b addr=%h exp req=1 addr=010", c, req_o, addr_o);
      end
    end
    @(negedge clk);
    checks++; if ({req_o, rready_o} !== 2'b01) begin
      errors++; $display("FAIL gw_rsp_state req=%b rready=%b exp 0 1", req_o, rready_o);
    end
    @(negedge clk);
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, proto_err_o} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL gw_rsp valid=%b err=%b rdata=%h proto=%b exp 1 0 deadbeef 0",
                         rsp_valid_o, rsp_err_o, rsp_rdata_o, proto_err_o);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    gnt_delay = 0;
  endtask

  task automatic test_byte_enable();
    logic got; logic [31:0] rd; logic rerr;
    run_txn(1'b1, 10'h3FF, 32'h12345678, 4'hF, got, rd, rerr);
    run_txn(1'b1, 10'h3FF, 32'hA5A5A5A5, 4'b0101, got, rd, rerr);
    checks++; if ({got, rd, rerr} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL be_write got=%b rdata=%h err=%b exp 1 0 0", got, rd, rerr);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h3FF; cmd_be = 4'hF;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++; if ({rsp_valid_o, rready_o, cmd_ready_o, rsp_rdata_o} !== {3'b100, 32'h12A556A5}) begin
        errors++; $display("FAIL bp_hold_c%0d valid=%b rready=%b ready=%b rdata=%h exp 1 0 0 12a556a5",
                           c, rsp_valid_o, rready_o, cmd_ready_o, rsp_rdata_o);
      end
      @(negedge clk);
    end
    checks++; if ({rsp_valid_o, rsp_rdata_o, rsp_err_o} !== {1'b1, 32'h12A556A5, 1'b0}) begin
      errors++; $display("FAIL bp_deliver valid=%b rdata=%h err=%b exp 1 12a556a5 0", rsp_valid_o, rsp_rdata_o, rsp_err_o);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_drain rsp_valid=%b exp=0", rsp_valid_o);
    end
  endtask

  task automatic test_timeout_req();
    gnt_never = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h020; cmd_be = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (req_o !== 1'b1) begin
        errors++; $display("FAIL tor_req_c%0d req_o=%b exp=1", c, req_o);
      end
    end
    @(negedge clk);
    checks++; if ({req_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, proto_err_o, cmd_ready_o} !== {3'b011, 32'h0, 2'b10}) begin
      errors++; $display("FAIL tor_expire req=%b valid=%b err=%b rdata=%h proto=%b ready=%b exp 0 1 1 0 1 0",
                         req_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, proto_err_o, cmd_ready_o);
    end
    gnt_never = 1'b0; rsp_ready = 1'b1; stray = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; stray = 1'b0;
    checks++; if ({proto_err_o, rsp_valid_o, par_err_o} !== 3'b100) begin
      errors++; $display("FAIL tor_late proto=%b valid=%b par=%b exp 1 0 0", proto_err_o, rsp_valid_o, par_err_o);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (proto_err_o !== 1'b0) begin
      errors++; $display("FAIL tor_clr proto_err_o=%b exp=0", proto_err_o);
    end
    stray = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    stray = 1'b0; err_clr = 1'b0;
    checks++; if (proto_err_o !== 1'b1) begin
      errors++; $display("FAIL tor_set_wins proto_err_o=%b exp=1", proto_err_o);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_timeout_rsp();
    rsp_never = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h010; cmd_be = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (req_o !== 1'b1) begin
      errors++; $display("FAIL tos_req req_o=%b exp=1", req_o);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if ({rready_o, rsp_valid_o} !== 2'b10) begin
        errors++; $display("FAIL tos_wait_c%0d rready=%b valid=%b exp 1 0", c, rready_o, rsp_valid_o);
      end
    end
    @(negedge clk);
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_we_o, rsp_rdata_o, rready_o, proto_err_o} !== {3'b110, 32'h0, 2'b01}) begin
      errors++; $display("FAIL tos_expire valid=%b err=%b we=%b rdata=%h rready=%b proto=%b exp 1 1 0 0 0 1",
                         rsp_valid_o, rsp_err_o, rsp_we_o, rsp_rdata_o, rready_o, proto_err_o);
    end
    flush = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; rsp_never = 1'b0; rsp_ready = 1'b0; err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if ({proto_err_o, rsp_valid_o} !== 2'b00) begin
      errors++; $display("FAIL tos_after proto=%b valid=%b exp 0 0", proto_err_o, rsp_valid_o);
    end
  endtask

  task automatic test_parity();
    logic got; logic [31:0] rd; logic rerr;
    @(negedge clk);
    flip_gpar = 1'b1;
    @(negedge clk);
    flip_gpar = 1'b0;
    checks++; if (par_err_o !== 1'b1) begin
      errors++; $display("FAIL par_gnt_set par_err_o=%b exp=1", par_err_o);
    end
    run_txn(1'b1, 10'h001, 32'hCAFEF00D, 4'hF, got, rd, rerr);
    run_txn(1'b0, 10'h001, 32'h0, 4'hF, got, rd, rerr);
    checks++; if ({got, rd, rerr, par_err_o, proto_err_o} !== {1'b1, 32'hCAFEF00D, 3'b010}) begin
      errors++; $display("FAIL par_flow got=%b rdata=%h err=%b par=%b proto=%b exp 1 cafef00d 0 1 0",
                         got, rd, rerr, par_err_o, proto_err_o);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (par_err_o !== 1'b0) begin
      errors++; $display("FAIL par_clr par_err_o=%b exp=0", par_err_o);
    end
    flip_rpar = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    flip_rpar = 1'b0; err_clr = 1'b0;
    checks++; if (par_err_o !== 1'b1) begin
      errors++; $display("FAIL par_rvalid_set_wins par_err_o=%b exp=1", par_err_o);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (par_err_o !== 1'b0) begin
      errors++; $display("FAIL par_clr2 par_err_o=%b exp=0", par_err_o);
    end
  endtask

  task automatic test_reset_mid();
    logic got; logic [31:0] rd; logic rerr;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h010; cmd_be = 4'hF;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({req_o, rready_o, rsp_valid_o, cmd_ready_o} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_now req/rready/valid/ready=%b exp=0000",
                         {req_o, rready_o, rsp_valid_o, cmd_ready_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({cmd_ready_o, rsp_valid_o, proto_err_o} !== 3'b100) begin
      errors++; $display("FAIL rstmid_after ready=%b valid=%b proto=%b exp 1 0 0", cmd_ready_o, rsp_valid_o, proto_err_o);
    end
    run_txn(1'b0, 10'h010, 32'h0, 4'hF, got, rd, rerr);
    checks++; if ({got, rd, rerr} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL rstmid_txn got=%b rdata=%h err=%b exp 1 deadbeef 0", got, rd, rerr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    rsp_ready = 1'b0; err_clr = 1'b0;
    gnt_never = 1'b0; rsp_never = 1'b0; flip_gpar = 1'b0; flip_rpar = 1'b0;
    stray = 1'b0; flush = 1'b0; gnt_delay = 0;
    test_reset();
    test_write();
    test_read();
    test_gnt_wait();
    test_byte_enable();
    test_backpressure();
    test_timeout_req();
    test_timeout_rsp();
    test_parity();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
